// File: rtl/lenet_pkg.sv
// Shared types and constants for the LeNet image-buffer write side.
// Holds the writer FSM state encoding, frame geometry and the error digit code.
// Pixel width is 8, matching the codebase WD macro.
package lenet_pkg;

    localparam int WD = 8;

    localparam int N_PIX = 784;
    localparam int AW    = 10;

    localparam logic [3:0] ERR_DIGIT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESULT
    } state_t;

endpackage

// File: rtl/image_wr_port.sv
// Registered SRAM write-port driver: turns an accept/address/data triple into cenb/wenb/ab/db.
// Latency: 1 cycle from wr_en to the active-low enables on the SRAM port.
// Backpressure: none; the SRAM write port always accepts, so every wr_en becomes a write.
// Ports: clk, rst (sync, active high), wr_en/wr_addr/wr_data in; cenb/wenb/ab/db out.
module image_wr_port #(
    parameter int AW = 10,
    parameter int WD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [WD-1:0] wr_data,
    output logic          cenb,
    output logic          wenb,
    output logic [AW-1:0] ab,
    output logic [WD-1:0] db
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cenb <= 1'b1;
            wenb <= 1'b1;
            ab   <= '0;
            db   <= '0;
        end else begin
            cenb <= ~wr_en;
            wenb <= ~wr_en;
            // Address/data hold their last value on idle cycles; the enables gate them.
            if (wr_en) begin
                ab <= wr_addr;
                db <= wr_data;
            end
        end
    end

endmodule

// File: rtl/image_writer.sv
// Loads one 28x28 frame into the image SRAM, starts the lenet core, and returns its digit.
// Latency: one SRAM write per accepted pixel (1 cycle later); go 1 cycle after the last accept.
// Backpressure: s_ready only in IDLE/LOAD; the result is held on res_valid until res_ready.
// Ports: pixel stream s_valid/s_data/s_last/s_ready, SRAM port cenb/wenb/ab/db,
// lenet handshake go/lenet_ready/lenet_digit, result res_valid/res_ready/res_digit/res_err, busy.
// Optional: LENET_WDOG_EN bounds the wait for lenet_ready to WDOG_CYC cycles.
module image_writer
    import lenet_pkg::*;
#(
    parameter int WD       = lenet_pkg::WD,
    parameter int N_PIX    = lenet_pkg::N_PIX,
    parameter int AW       = lenet_pkg::AW,
    parameter int WDOG_CYC = 200000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [WD-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          cenb,
    output logic          wenb,
    output logic [AW-1:0] ab,
    output logic [WD-1:0] db,
    output logic          go,
    input  logic          lenet_ready,
    input  logic [3:0]    lenet_digit,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [3:0]    res_digit,
    output logic          res_err,
    output logic          busy
);

    state_t        state, state_nxt;
    logic [AW-1:0] count, count_nxt;
    logic          accept;
    logic          last_idx;
    logic          cap_ok, cap_err;

    logic          s_ready_d, go_d, res_valid_d, busy_d, res_err_d;
    logic [3:0]    res_digit_d;

    // s_ready is registered and only ever high in IDLE/LOAD, so accept implies one of those states.
    assign accept   = s_valid & s_ready;
    assign last_idx = (count == AW'(N_PIX - 1));

`ifdef LENET_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYC + 1);
    logic [WDW-1:0] wdog_cnt;
    logic           wdog_hit;

    // The WAIT cycle in which the count would reach WDOG_CYC is the timeout cycle.
    assign wdog_hit = (wdog_cnt == WDW'(WDOG_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`endif

    // State register plus frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        cap_ok    = 1'b0;
        cap_err   = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (last_idx) begin
                        // Full frame: s_last here is expected but not required.
                        state_nxt = START;
                        count_nxt = '0;
                    end else if (s_last) begin
                        // Short frame: the beat carrying s_last is still written, then abort.
                        state_nxt = RESULT;
                        count_nxt = '0;
                        cap_err   = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                        count_nxt = count + 1'b1;
                    end
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                if (lenet_ready) begin
                    state_nxt = RESULT;
                    cap_ok    = 1'b1;
                end
`ifdef LENET_WDOG_EN
                else if (wdog_hit) begin
                    state_nxt = RESULT;
                    cap_err   = 1'b1;
                end
`endif
            end
            RESULT: begin
                if (res_valid && res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output can be registered.
    always_comb begin
        s_ready_d   = (state_nxt == IDLE) || (state_nxt == LOAD);
        go_d        = (state_nxt == START);
        res_valid_d = (state_nxt == RESULT);
        busy_d      = (state_nxt != IDLE);
        res_digit_d = res_digit;
        res_err_d   = res_err;
        if (cap_ok) begin
            res_digit_d = lenet_digit;
            res_err_d   = 1'b0;
        end else if (cap_err) begin
            res_digit_d = ERR_DIGIT;
            res_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready   <= 1'b0;
            go        <= 1'b0;
            res_valid <= 1'b0;
            res_digit <= 4'h0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            s_ready   <= s_ready_d;
            go        <= go_d;
            res_valid <= res_valid_d;
            res_digit <= res_digit_d;
            res_err   <= res_err_d;
            busy      <= busy_d;
        end
    end

    image_wr_port #(
        .AW (AW),
        .WD (WD)
    ) u_wr_port (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (count),
        .wr_data (s_data),
        .cenb    (cenb),
        .wenb    (wenb),
        .ab      (ab),
        .db      (db)
    );

endmodule
